spi_coeff_master: RTL
=====================

// Module: spi_coeff_master
// PURPOSE
//  SPI mode-0 initiator that streams FIR coefficient words into the FIR engine's write-only SPI port.
//  It drives spiClk/mosi/cs. Words arrive over a valid/ready stream, are sent MSB first, and one cs-low
//  frame carries up to NTaps words. It is used as the FPGA/bench-side loader and as the on-chip boot
//  loader in front of the engine.
// PARAMETERS
//  DataWidth  8   bits per coefficient word (>=2)
//  NTaps      13  max words per cs frame; the frame closes after word NTaps even without coefLast
//  ClkDiv     4   clk cycles per spiClk half-period (>=2); bit period = 2*ClkDiv
// PORTS
//  clk        in   1              system clock; all logic on rising edge
//  reset      in   1              synchronous, active-high reset
//  coefData   in   DataWidth      coefficient word, MSB first on the wire
//  coefValid  in   1              coefData valid
//  coefLast   in   1              qualifies coefData: final word of this frame
//  coefReady  out  1              word accepted when coefValid&&coefReady on a clk edge
//  spiClk     out  1              SPI clock, idle low (CPOL=0)
//  mosi       out  1              SPI data; changes only while spiClk low, stable across rising edge
//  cs         out  1              active-low chip select, high between frames
//  busy       out  1              high whenever state != IDLE
//  done       out  1              one-cycle pulse in the cycle cs returns high
//  wordCount  out  $clog2(NTaps+1) words accepted in current/last frame; cleared on first word of a frame
// BEHAVIOUR
//  Reset: cs=1, spiClk=0, mosi=0, coefReady=0, busy=0, done=0, wordCount=0, state=IDLE, divider=0.
//  Reset mid-frame: the same values apply on the next edge. The partial word is discarded and no done pulse is issued.
//  Registered outputs: no combinational path from inputs to SPI pins. coefReady is decoded from state only.
//  States:
//   IDLE:    coefReady=1. On handshake: shift<=coefData, mosi<=coefData[MSB], cs<=0, bitCnt<=DataWidth-1,
//            last<=coefLast||(NTaps==1), wordCount<=1 -> SETUP.
//   SETUP/LOW: spiClk low; after ClkDiv cycles spiClk<=1 -> HIGH.
//   HIGH:    after ClkDiv cycles spiClk<=0.
//            If bitCnt==0 -> WORDEND.
//            Else shift left, mosi<=next bit, bitCnt-- -> LOW.
//   WORDEND: spiClk=0, cs=0, mosi holds the last bit.
//            If last: after ClkDiv cycles cs<=1, done<=1 -> GAP.
//            Else coefReady=1 and it waits indefinitely (cs stays low). On handshake: load as in IDLE,
//            wordCount++, last<=coefLast||(wordCount+1==NTaps) -> LOW.
//   GAP:     cs=1 for ClkDiv cycles (min deselect time) -> IDLE.
//  Timing, first handshake at edge t0 (ClkDiv=D, DataWidth=W):
//   - cs falls and MSB appears at t0+1.
//   - Rising edges at t0+1+D+2kD, for k=0..W-1.
//   - Final falling edge at t0+1+2WD.
//   - Mid-frame, the next handshake at edge tn puts the MSB at tn+1 and its first rising edge at tn+1+D.
//   - For the last word, cs rises (and done pulses) at t_lastfall+D. coefReady returns at that +D.
//  coefValid low in WORDEND only stretches the gap between words. It never drops cs.
//  coefLast is ignored except on handshake cycles.
//  The NTaps-th word forces frame end. wordCount saturates at NTaps and never wraps.
//  Divider counts 0..ClkDiv-1 and restarts on every state change.
// TESTING
//  1 Reset: hold reset 3 cycles -> cs=1, spiClk=0, mosi=0, coefReady=0, busy=0. First cycle after reset -> coefReady=1.
//  2 Single word 0xA5 with coefLast=1 (D=4, t0=0):
//    - cs falls at 1.
//    - Bits 1,0,1,0,0,1,0,1 sampled on rising edges at 5,13,...,61.
//    - Last falling edge at 65; cs rises and done pulses at 69; coefReady at 73.
//  3 Frame of 3 words 0x01,0x80,0xFF (last on third), valid always high:
//    - cs stays low throughout; 24 rising edges; wordCount=3; exactly one done.
//  4 Back-pressure: deassert coefValid for 20 cycles between words 1 and 2.
//    -> cs stays low, spiClk stays low, no extra edges, and word 2 is received intact.
//  5 Forced close: 14 words with coefLast=0.
//    -> cs rises after word 13 and wordCount=13. Word 14 starts a new frame with wordCount=1.
//  6 Reset asserted at cycle 30 of a word -> cs=1 at 31, no done pulse. A following word 0x3C is received correctly.

Source files
------------

// File: rtl/spi_coeff_master.sv
// SPI mode-0 initiator that streams valid/ready coefficient words MSB first,
// packing up to NTaps words into one cs-low frame.
module spi_coeff_master #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned NTaps     = 13,
  parameter int unsigned ClkDiv    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DataWidth-1:0]       coefData,
  input  logic                       coefValid,
  input  logic                       coefLast,
  output logic                       coefReady,
  output logic                       spiClk,
  output logic                       mosi,
  output logic                       cs,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NTaps+1)-1:0] wordCount
);

  localparam int unsigned DIV_W = $clog2(ClkDiv);
  localparam int unsigned BIT_W = $clog2(DataWidth);
  localparam int unsigned CNT_W = $clog2(NTaps + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ClkDiv - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DataWidth - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WORDEND,
    ST_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 cs_d, sclk_d, mosi_d, done_d, busy_d, ready_d;
  logic                 handshake;
  logic                 div_end;

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    cnt_d     = wordCount;
    cs_d      = cs;
    sclk_d    = spiClk;
    mosi_d    = mosi;
    done_d    = 1'b0;
    handshake = coefValid && coefReady;
    div_end   = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          shift_d   = coefData;
          mosi_d    = coefData[DataWidth-1];
          bit_cnt_d = BIT_LAST;
          cs_d      = 1'b0;
          cnt_d     = CNT_W'(1);
          last_d    = coefLast || (NTaps == 32'd1);
          div_d     = '0;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (div_end) begin
          sclk_d  = 1'b1;
          div_d   = '0;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (div_end) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bit_cnt_q == '0) begin
            state_d = ST_WORDEND;
          end else begin
            shift_d   = shift_q << 1;
            mosi_d    = shift_q[DataWidth-2];
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            state_d   = ST_LOW;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_WORDEND: begin
        if (last_q) begin
          if (div_end) begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            div_d   = '0;
            state_d = ST_GAP;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end else if (handshake) begin
          // Mid-frame word: cs stays low, word count drives the forced close
          shift_d   = coefData;
          mosi_d    = coefData[DataWidth-1];
          bit_cnt_d = BIT_LAST;
          cnt_d     = wordCount + CNT_W'(1);
          last_d    = coefLast || ((32'(wordCount) + 32'd1) == NTaps);
          div_d     = '0;
          state_d   = ST_LOW;
        end
      end
      ST_GAP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE) || ((state_d == ST_WORDEND) && !last_d);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      wordCount <= '0;
      cs        <= 1'b1;
      spiClk    <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      coefReady <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      wordCount <= cnt_d;
      cs        <= cs_d;
      spiClk    <= sclk_d;
      mosi      <= mosi_d;
      done      <= done_d;
      busy      <= busy_d;
      coefReady <= ready_d;
    end
  end

endmodule
